// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the adder_arbiter slice: output-stage state
// encoding and the requester-ID width helper.
package adder_arb_pkg;

  // Output register occupancy: EMPTY means no response held, FULL means
  // rsp_* carries a result waiting for the consumer.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // Requester-ID width: $clog2(n), but never narrower than one bit.
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Bundle of request and response handshake signals for adder_arbiter.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. A requester that raises
// req_valid[i] keeps req_a/req_b slice i stable and req_valid[i] high until
// it sees req_ready[i]. The response side holds rsp_id/rsp_sum/rsp_cout
// stable while rsp_valid is high and rsp_ready is low.
interface adder_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = adder_arb_pkg::idw(NREQ)
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;

  // Client side: requesters and the response consumer.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

endinterface

// File: rtl/adder.sv
// Plain WIDTH-bit ripple-carry adder with carry in and carry out.
module adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Ripple the carry bit by bit from LSB to MSB.
  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/adder_arbiter_rr_arbiter.sv
// Combinational requester search for adder_arbiter.
// Default: round-robin, first set request at or above ptr with wrap.
// With ADDER_ARB_FIXED_PRIO_EN defined: lowest index wins, ptr ignored.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_any
);

`ifdef ADDER_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  // Walk search steps in priority order; the candidate for each step is
  // matched against every index so no variable bit-select is needed.
  always_comb begin
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
      idx = i;
`else
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
`endif
      for (int j = 0; j < NREQ; j++) begin
        if (en && !found && req[j] && (idx == j)) begin
          found     = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = IDW'(j);
        end
      end
    end
    grant_any = found;
  end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one ripple-carry adder among NREQ requesters and
// returns one registered, ID-tagged result per grant on a single response
// port. Optional build macro: ADDER_ARB_FIXED_PRIO_EN selects fixed
// lowest-index-wins priority instead of round-robin.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  adder_arbiter_if.slave  bus,
  output out_state_e      dbg_state
);

  localparam int IDW = idw(NREQ);

  out_state_e       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             can_accept;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic             grant_any;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  // The output register can take a new result when it is empty or is
  // being drained this very cycle (back-to-back, no bubble).
  assign can_accept = (state_q == EMPTY) || bus.rsp_ready;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .en        (can_accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Steer the granted requester's operands into the shared adder.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        op_a = bus.req_a[i*WIDTH +: WIDTH];
        op_b = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Next state: capture on grant, otherwise drop to EMPTY when drained.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (grant_any) begin
      state_d = FULL;
      id_d    = grant_idx;
      sum_d   = add_sum;
      cout_d  = add_cout;
`ifdef ADDER_ARB_FIXED_PRIO_EN
      ptr_d   = ptr_q;
`else
      ptr_d   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
`endif
    end else if ((state_q == FULL) && bus.rsp_ready) begin
      state_d = EMPTY;
    end
  end

  // State, pointer and response registers; reset discards any held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = (state_q == FULL);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: table of single-request vectors,
// directed multi-cycle sequences, a random phase, and a reference model
// feeding an expected-result queue checked on every response.
module tb_adder_arbiter;
  import adder_arb_pkg::*;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = idw(NREQ);
  localparam int EW    = IDW + 1 + WIDTH;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             cout;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  out_state_e dbg_state;

  adder_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int              n_cmp;
  int              n_err;
  logic [EW-1:0]   exp_q[$];
  int              grant_log[$];
  logic            m_full;
  int              m_ptr;
  logic [NREQ-1:0] last_grant;
  vec_t            vecs[6];
  int              exp_order[5];

  // Watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int glog(input int k);
    return (k < grant_log.size()) ? grant_log[k] : -1;
  endfunction

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic model_reset();
    m_full     = 1'b0;
    m_ptr      = 0;
    last_grant = '0;
    exp_q.delete();
  endtask

  // Reference model and scoreboard, evaluated mid-cycle on the falling edge.
  task automatic monitor();
    logic [NREQ-1:0] exp_rdy;
    logic [WIDTH:0]  s;
    int              g;
    int              k;
    logic            can;
    can = !m_full || bus.rsp_ready;
    g   = -1;
    if (can) begin
      for (int i = 0; i < NREQ; i++) begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
        k = i;
`else
        k = (m_ptr + i) % NREQ;
`endif
        if (g < 0 && bus.req_valid[k]) g = k;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("rsp_valid", bus.rsp_valid, m_full);
    if (m_full) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow: response held with no expected entry (t=%0t)", $time);
      end else begin
        chk("rsp_data", {bus.rsp_id, bus.rsp_cout, bus.rsp_sum}, exp_q[0]);
        if (bus.rsp_ready) void'(exp_q.pop_front());
      end
    end
    last_grant = exp_rdy;
    if (g >= 0) begin
      s = {1'b0, bus.req_a[g*WIDTH +: WIDTH]} + {1'b0, bus.req_b[g*WIDTH +: WIDTH]};
      exp_q.push_back({IDW'(g), s});
      grant_log.push_back(g);
      m_ptr  = (g + 1) % NREQ;
      m_full = 1'b1;
    end else if (can) begin
      m_full = 1'b0;
    end
  endtask

  // One clock: check at the falling edge, return 1 time unit past the rise.
  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.rsp_valid, 1'b0);
    chk("rst_id", bus.rsp_id, '0);
    chk("rst_sum", bus.rsp_sum, '0);
    chk("rst_cout", bus.rsp_cout, 1'b0);
    chk("rst_state", dbg_state, EMPTY);
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    model_reset();

    vecs[0] = '{id: 0, a: 8'h12, b: 8'h34, sum: 8'h46, cout: 1'b0};
    vecs[1] = '{id: 2, a: 8'hFF, b: 8'h01, sum: 8'h00, cout: 1'b1};
    vecs[2] = '{id: 1, a: 8'h80, b: 8'h80, sum: 8'h00, cout: 1'b1};
    vecs[3] = '{id: 3, a: 8'h7F, b: 8'h01, sum: 8'h80, cout: 1'b0};
    vecs[4] = '{id: 0, a: 8'hFF, b: 8'hFF, sum: 8'hFE, cout: 1'b1};
    vecs[5] = '{id: 1, a: 8'h00, b: 8'h00, sum: 8'h00, cout: 1'b0};
`ifdef ADDER_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif

    do_reset();

    // Table of single requests, one-cycle latency checks
    bus.rsp_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      bus.req_valid = '0;
      bus.req_valid[vecs[v].id] = 1'b1;
      set_op(vecs[v].id, vecs[v].a, vecs[v].b);
      #1;
      chk("tbl_ready", bus.req_ready, 32'(1) << vecs[v].id);
      cycle();
      bus.req_valid = '0;
      #1;
      chk("tbl_valid", bus.rsp_valid, 1'b1);
      chk("tbl_id", bus.rsp_id, vecs[v].id);
      chk("tbl_sum", bus.rsp_sum, vecs[v].sum);
      chk("tbl_cout", bus.rsp_cout, vecs[v].cout);
      cycle();
    end

    // All four requesting: back-to-back grants in round-robin order
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, WIDTH'(8'h10 * (i + 1)), WIDTH'(8'h03 + i));
    bus.req_valid = '1;
    grant_log.delete();
    repeat (5) cycle();
    bus.req_valid = '0;
    chk("order_count", grant_log.size(), 5);
    for (int k = 0; k < 5; k++) chk("order_grant", glog(k), exp_order[k]);
    repeat (2) cycle();

    // Backpressure: one grant, response held, then immediate regrant
    do_reset();
    grant_log.delete();
    bus.rsp_ready = 1'b0;
    set_op(0, 8'h21, 8'h43);
    set_op(1, 8'hC0, 8'h55);
    bus.req_valid = 4'b0011;
    cycle();
    bus.req_valid = 4'b0010;
    repeat (3) begin
      #1;
      chk("bp_state", dbg_state, FULL);
      chk("bp_ready", bus.req_ready, '0);
      cycle();
    end
    chk("bp_grants", grant_log.size(), 1);
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_regrant", bus.req_ready, 4'b0010);
    cycle();
    bus.req_valid = '0;
    chk("bp_second", glog(1), 1);
    repeat (2) cycle();

    // Pointer wrap: grant 2, then 3 and 0 compete
    do_reset();
    bus.rsp_ready = 1'b1;
    set_op(2, 8'h01, 8'h02);
    set_op(3, 8'hF0, 8'h20);
    set_op(0, 8'h0A, 8'h0B);
    bus.req_valid = 4'b0100;
    cycle();
    grant_log.delete();
    bus.req_valid = 4'b1001;
    repeat (2) cycle();
    bus.req_valid = '0;
`ifdef ADDER_ARB_FIXED_PRIO_EN
    chk("wrap_first", glog(0), 0);
`else
    chk("wrap_first", glog(0), 3);
`endif
    chk("wrap_second", glog(1), 0);
    repeat (2) cycle();

    // Random traffic honouring the hold-until-granted rule
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(bus.req_valid[i] && !last_grant[i])) begin
          bus.req_valid[i] = ($urandom_range(0, 2) != 0);
          set_op(i, WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)));
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) cycle();
    chk("sb_drain", exp_q.size(), 0);

    // Asynchronous reset while FULL, then ptr back at 0
    bus.rsp_ready = 1'b0;
    set_op(0, 8'h11, 8'h22);
    bus.req_valid = 4'b0001;
    cycle();
    bus.req_valid = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.rsp_valid, 1'b0);
    chk("arst_state", dbg_state, EMPTY);
    model_reset();
    #1 rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, WIDTH'(8'h40 + i), WIDTH'(8'h01));
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    grant_log.delete();
    cycle();
    bus.req_valid = '0;
    chk("arst_first", glog(0), 0);
    repeat (2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
